// File: rtl/collatz_dispatch.sv
// Shares NUM_ENGINES external collatz engines across RAM_WORDS consecutive start values.
// Optional macro COLLATZ_DISPATCH_TIMEOUT_EN: stuck engines saturate at 16'hFFFF and set overflow.
`timescale 1ns/1ps
module collatz_dispatch #(
   parameter int NUM_ENGINES   = 4,
   parameter int RAM_WORDS     = 16,
   parameter int RAM_ADDR_BITS = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     go,
   input  logic [31:0]              start,
   output logic                     busy,
   output logic                     done,
   input  logic [RAM_ADDR_BITS-1:0] rd_addr,
   output logic [15:0]              rd_data,
   output logic [NUM_ENGINES-1:0]   eng_go,
   output logic [31:0]              eng_n,
   input  logic [NUM_ENGINES-1:0]   eng_done,
   output logic                     overflow
);
   localparam int CW = RAM_ADDR_BITS + 1;
   localparam int EW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                   state_reg;
   logic [31:0]              next_n_reg;
   logic [CW-1:0]            issue_idx_reg;
   logic [CW-1:0]            wr_cnt_reg;
   logic [NUM_ENGINES-1:0]   eng_busy_reg;
   logic [RAM_ADDR_BITS-1:0] tag_reg [NUM_ENGINES];
   logic [15:0]              cnt_reg [NUM_ENGINES];
   logic [15:0]              ram [RAM_WORDS];

   logic [NUM_ENGINES-1:0]   fin;
   logic [NUM_ENGINES-1:0]   inc_en;
   logic [NUM_ENGINES-1:0]   sat;
   logic [EW-1:0]            wr_sel;
   logic [EW-1:0]            iss_sel;
   logic                     wr_any;
   logic                     iss_any;
   logic                     can_issue;
   logic [15:0]              wr_data;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_ENGINES; gi++) begin : g_eng
`ifdef COLLATZ_DISPATCH_TIMEOUT_EN
         assign sat[gi] = (cnt_reg[gi] == 16'hFFFF);
`else
         assign sat[gi] = 1'b0;
`endif
         // In the issue cycle eng_done still reflects the previous sequence, so it is masked.
         assign fin[gi]    = eng_busy_reg[gi] & ~eng_go[gi] & (eng_done[gi] | sat[gi]);
         assign inc_en[gi] = (state_reg == S_RUN) & eng_busy_reg[gi] & ~eng_go[gi]
                             & ~eng_done[gi] & ~sat[gi];
      end
   endgenerate

   always_comb begin
      wr_sel  = '0;
      wr_any  = 1'b0;
      iss_sel = '0;
      iss_any = 1'b0;
      for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
         if (fin[i]) begin
            wr_sel = EW'(i);
            wr_any = 1'b1;
         end
         if (!eng_busy_reg[i]) begin
            iss_sel = EW'(i);
            iss_any = 1'b1;
         end
      end
   end

   assign can_issue = (state_reg == S_RUN) && iss_any && (issue_idx_reg < CW'(RAM_WORDS));
   assign wr_data   = eng_done[wr_sel] ? cnt_reg[wr_sel] : 16'hFFFF;

`ifdef COLLATZ_DISPATCH_TIMEOUT_EN
   logic overflow_reg;
   assign overflow = overflow_reg;
`else
   assign overflow = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= S_IDLE;
         next_n_reg    <= '0;
         issue_idx_reg <= '0;
         wr_cnt_reg    <= '0;
         eng_busy_reg  <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         eng_go        <= '0;
         eng_n         <= '0;
`ifdef COLLATZ_DISPATCH_TIMEOUT_EN
         overflow_reg  <= 1'b0;
`endif
         for (int i = 0; i < NUM_ENGINES; i++) begin
            tag_reg[i] <= '0;
            cnt_reg[i] <= '0;
         end
      end else begin
         eng_go <= '0;
         for (int i = 0; i < NUM_ENGINES; i++) begin
            if (inc_en[i]) cnt_reg[i] <= cnt_reg[i] + 16'd1;
         end
         case (state_reg)
            S_IDLE, S_DONE: begin
               if (go) begin
                  state_reg     <= S_RUN;
                  next_n_reg    <= start;
                  issue_idx_reg <= '0;
                  wr_cnt_reg    <= '0;
                  busy          <= 1'b1;
                  done          <= 1'b0;
`ifdef COLLATZ_DISPATCH_TIMEOUT_EN
                  overflow_reg  <= 1'b0;
`endif
               end
            end
            S_RUN: begin
               if (can_issue) begin
                  eng_go[iss_sel]       <= 1'b1;
                  eng_n                 <= next_n_reg;
                  eng_busy_reg[iss_sel] <= 1'b1;
                  tag_reg[iss_sel]      <= issue_idx_reg[RAM_ADDR_BITS-1:0];
                  cnt_reg[iss_sel]      <= 16'd1;
                  issue_idx_reg         <= issue_idx_reg + 1'b1;
                  next_n_reg            <= next_n_reg + 32'd1;
               end
               if (wr_any) begin
                  eng_busy_reg[wr_sel] <= 1'b0;
                  wr_cnt_reg           <= wr_cnt_reg + 1'b1;
`ifdef COLLATZ_DISPATCH_TIMEOUT_EN
                  if (!eng_done[wr_sel]) overflow_reg <= 1'b1;
`endif
                  if (wr_cnt_reg == CW'(RAM_WORDS - 1)) begin
                     state_reg <= S_DONE;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // Result RAM: no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_any && state_reg == S_RUN) ram[tag_reg[wr_sel]] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rd_data <= '0;
      else          rd_data <= ram[rd_addr];
   end
endmodule

// File: tb/tb_collatz_dispatch.sv
// Directed bench for collatz_dispatch with real-collatz and fixed-delay stub engine models.
`timescale 1ns/1ps
module tb_collatz_dispatch;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Main instance: 2 engines, 16 results.
   logic        m_go_in = 1'b0;
   logic [31:0] m_start = '0;
   logic        m_busy, m_done, m_ovf;
   logic [3:0]  m_rd_addr = '0;
   logic [15:0] m_rd_data;
   logic [1:0]  m_eng_go, m_eng_done;
   logic [31:0] m_eng_n;

   collatz_dispatch #(.NUM_ENGINES(2), .RAM_WORDS(16), .RAM_ADDR_BITS(4)) u_main (
      .clk(clk), .reset_n(reset_n), .go(m_go_in), .start(m_start), .busy(m_busy),
      .done(m_done), .rd_addr(m_rd_addr), .rd_data(m_rd_data), .eng_go(m_eng_go),
      .eng_n(m_eng_n), .eng_done(m_eng_done), .overflow(m_ovf));

   // Small instance: 2 engines, 2 results, stub engines only.
   logic        s_go_in = 1'b0;
   logic [31:0] s_start = '0;
   logic        s_busy, s_done, s_ovf;
   logic [0:0]  s_rd_addr = '0;
   logic [15:0] s_rd_data;
   logic [1:0]  s_eng_go, s_eng_done;
   logic [31:0] s_eng_n;

   collatz_dispatch #(.NUM_ENGINES(2), .RAM_WORDS(2), .RAM_ADDR_BITS(1)) u_small (
      .clk(clk), .reset_n(reset_n), .go(s_go_in), .start(s_start), .busy(s_busy),
      .done(s_done), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .eng_go(s_eng_go),
      .eng_n(s_eng_n), .eng_done(s_eng_done), .overflow(s_ovf));

   // Main engine models: real collatz, or stub done (15 - n[3:0]) cycles after load (count 16-n[3:0]).
   logic [31:0] m_n [2] = '{32'd0, 32'd0};
   logic [3:0]  m_c [2] = '{4'd0, 4'd0};
   logic [1:0]  m_ld = '0;
   logic        stub_mode = 1'b0;

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (m_eng_go[i]) begin
            m_n[i]  <= m_eng_n;
            m_c[i]  <= ~m_eng_n[3:0];
            m_ld[i] <= 1'b1;
         end else begin
            if (m_n[i] > 32'd1) m_n[i] <= m_n[i][0] ? (m_n[i] * 32'd3 + 32'd1) : (m_n[i] >> 1);
            if (m_c[i] != 4'd0) m_c[i] <= m_c[i] - 4'd1;
         end
      end
   end

   always_comb begin
      m_eng_done = '0;
      for (int i = 0; i < 2; i++)
         m_eng_done[i] = m_ld[i] && (stub_mode ? (m_c[i] == 4'd0) : (m_n[i] == 32'd1));
   end

   logic [3:0] s_c [2] = '{4'd0, 4'd0};
   logic [1:0] s_ld = '0;

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (s_eng_go[i]) begin
            s_c[i]  <= ~s_eng_n[3:0];
            s_ld[i] <= 1'b1;
         end else if (s_c[i] != 4'd0) begin
            s_c[i] <= s_c[i] - 4'd1;
         end
      end
   end

   always_comb begin
      s_eng_done = '0;
`ifndef COLLATZ_DISPATCH_TIMEOUT_EN
      for (int i = 0; i < 2; i++) s_eng_done[i] = s_ld[i] && (s_c[i] == 4'd0);
`endif
   end

   // Issue monitors.
   int          cyc = 0;
   int          m_iss = 0;
   logic [31:0] iss_n [64];
   int          iss_e [64];
   int          iss_c [64];
   int          s_iss = 0;
   logic [31:0] s_iss_n [8];

   always @(posedge clk) begin
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) begin
         if (m_eng_go[i] && m_iss < 64) begin
            iss_n[m_iss] = m_eng_n;
            iss_e[m_iss] = i;
            iss_c[m_iss] = cyc;
            m_iss = m_iss + 1;
         end
         if (s_eng_go[i] && s_iss < 8) begin
            s_iss_n[s_iss] = s_eng_n;
            s_iss = s_iss + 1;
         end
      end
   end

   typedef struct {
      logic [3:0]  addr;
      logic [15:0] exp;
   } rvec_t;

   rvec_t tab_real [16];
   rvec_t tab_stub [16];
   int    real_cnt [16] = '{1, 2, 8, 3, 6, 9, 17, 4, 20, 7, 15, 10, 10, 18, 18, 5};

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", nm, got);
      end
   endtask

   task automatic m_pulse_go(input logic [31:0] s);
      @(negedge clk);
      m_go_in = 1'b1;
      m_start = s;
      @(negedge clk);
      m_go_in = 1'b0;
   endtask

   task automatic wait_m_done(input int bound, input string nm);
      int k = 0;
      while (!m_done && k < bound) begin
         @(negedge clk);
         k++;
      end
      chk(nm, 32'(m_done), 32'd1);
   endtask

   task automatic check_tab(input bit use_stub, input string pfx);
      rvec_t v;
      for (int i = 0; i < 16; i++) begin
         v = use_stub ? tab_stub[i] : tab_real[i];
         @(negedge clk);
         m_rd_addr = v.addr;
         @(negedge clk);
         chk($sformatf("%s_ram%0d", pfx, i), 32'(m_rd_data), 32'(v.exp));
      end
   endtask

   task automatic s_read(input logic [0:0] a, output logic [15:0] d);
      @(negedge clk);
      s_rd_addr = a;
      @(negedge clk);
      d = s_rd_data;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish within 2 ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          base;
      int          k;
      logic [15:0] d;

      for (int i = 0; i < 16; i++) begin
         tab_real[i].addr = 4'(i);
         tab_real[i].exp  = 16'(real_cnt[i]);
         tab_stub[i].addr = 4'(i);
         tab_stub[i].exp  = 16'(16 - ((5 + i) & 15));
      end

      // Reset state.
      #23;
      chk("rst_busy", 32'(m_busy), 32'd0);
      chk("rst_done", 32'(m_done), 32'd0);
      chk("rst_eng_go", 32'(m_eng_go), 32'd0);
      chk("rst_eng_n", m_eng_n, 32'd0);
      chk("rst_rd_data", 32'(m_rd_data), 32'd0);
      chk("rst_overflow", 32'(m_ovf), 32'd0);
      chk("rst_small_busy", 32'(s_busy), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Real run from 1, with a go pulse mid-run that must be ignored.
      stub_mode = 1'b0;
      base = m_iss;
      m_pulse_go(32'd1);
      chk("a_busy_after_go", 32'(m_busy), 32'd1);
      chk("a_no_issue_yet", 32'(m_eng_go), 32'd0);
      @(negedge clk);
      chk("a_first_eng_go", 32'(m_eng_go), 32'd1);
      chk("a_first_eng_n", m_eng_n, 32'd1);
      repeat (3) @(negedge clk);
      m_pulse_go(32'd100);
      wait_m_done(2000, "a_done");
      chk("a_busy_low", 32'(m_busy), 32'd0);
      chk("a_issue_count", 32'(m_iss - base), 32'd16);
      chk("a_last_eng_n", iss_n[base + 15], 32'd16);
      chk("a_overflow", 32'(m_ovf), 32'd0);
      check_tab(1'b0, "a");

      // Stub run from 5: every engine pair finishes in the same cycle.
      stub_mode = 1'b1;
      base = m_iss;
      m_pulse_go(32'd5);
      chk("b_done_cleared", 32'(m_done), 32'd0);
      wait_m_done(2000, "b_done");
      chk("b_n7_engine", 32'(iss_e[base + 2]), 32'd0);
      chk("b_n8_engine", 32'(iss_e[base + 3]), 32'd1);
      chk("b_n7_after_n6", 32'(iss_c[base + 2] - iss_c[base + 1]), 32'd12);
      chk("b_n8_after_n7", 32'(iss_c[base + 3] - iss_c[base + 2]), 32'd1);
      check_tab(1'b1, "b");

      // Asynchronous reset while an issue pulse is on the bus.
      stub_mode = 1'b0;
      m_rd_addr = 4'd0;
      m_pulse_go(32'd1);
      @(negedge clk);
      chk("c_eng_go_before", 32'(m_eng_go), 32'd1);
      chk("c_rd_data_before", 32'(m_rd_data), 32'd11);
      #2;
      reset_n = 1'b0;
      #1;
      chk("c_rst_busy", 32'(m_busy), 32'd0);
      chk("c_rst_done", 32'(m_done), 32'd0);
      chk("c_rst_eng_go", 32'(m_eng_go), 32'd0);
      chk("c_rst_rd_data", 32'(m_rd_data), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      m_pulse_go(32'd1);
      wait_m_done(2000, "c_done");
      check_tab(1'b0, "c");

      // Small instance: start value wraps from 32'hFFFFFFFF to 0.
      @(negedge clk);
      s_go_in = 1'b1;
      s_start = 32'hFFFF_FFFF;
      @(negedge clk);
      s_go_in = 1'b0;
      k = 0;
      while (!s_done && k < 70000) begin
         @(negedge clk);
         k++;
      end
      chk("d_done", 32'(s_done), 32'd1);
      chk("d_issue_count", 32'(s_iss), 32'd2);
      chk("d_eng_n_0", s_iss_n[0], 32'hFFFF_FFFF);
      chk("d_eng_n_1", s_iss_n[1], 32'h0000_0000);
`ifdef COLLATZ_DISPATCH_TIMEOUT_EN
      s_read(1'b0, d);
      chk("d_ram0_sat", 32'(d), 32'h0000_FFFF);
      s_read(1'b1, d);
      chk("d_ram1_sat", 32'(d), 32'h0000_FFFF);
      chk("d_overflow", 32'(s_ovf), 32'd1);
`else
      s_read(1'b0, d);
      chk("d_ram0", 32'(d), 32'd1);
      s_read(1'b1, d);
      chk("d_ram1", 32'(d), 32'd16);
      chk("d_overflow", 32'(s_ovf), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
